fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins execution at pc 0.
REQ-005 SHALL have port pc  output  PC_W  instruction memory address.
REQ-006 SHALL have port instr  input  9  instruction memory data, valid one cycle after pc.
REQ-007 SHALL have port rd1  input  8  register-file read port 1 data.
REQ-008 SHALL have port rd2  input  8  register-file read port 2 data.
REQ-009 SHALL have ports wen (output, 1), AccControl (output, 3), ra1 (output, 3) and ra2 (output, 3), which are the register-file controls.
REQ-010 SHALL have port imm  output  8  zero-extended instr[5:0].
REQ-011 SHALL have ports mem_we and mem_re (both output, 1), which are the data-memory write and read strobes.
REQ-012 SHALL have port done  output  1  high while halted.
REQ-013 SHALL have port cyc_cnt  output  16  cycles executed since start.

Function
REQ-014 SHALL run an FSM with states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-015 SHALL make these transitions:
- IDLE->FETCH on start.
- FETCH->DECODE->EXEC->WB unconditionally.
- WB->FETCH, except mode 0, which goes WB->HALT.
- HALT->FETCH on start.
REQ-016 SHALL latch the instruction register from instr on the FETCH->DECODE edge.
REQ-017 SHALL decode the instruction register fields as mode = IR[8:6], ra1 = IR[5:3], ra2 = IR[2:0], imm = {2'b00, IR[5:0]}.
REQ-018 SHALL drive AccControl = mode, together with ra1 and ra2, during DECODE, EXEC and WB; otherwise these outputs SHALL be 0.
REQ-019 SHALL pulse wen for exactly the WB cycle, and only for modes 1, 2, 6 and 7.
REQ-020 SHALL pulse mem_re during EXEC for mode 6 only, and mem_we during WB for mode 5 only.
REQ-021 SHALL, for mode 3 in EXEC, latch eq_flag <= (rd1 == rd2).
REQ-022 SHALL, for mode 4 in WB, load pc <= zero-extended rd1 sampled in EXEC when eq_flag is 1, else pc <= pc+1; eq_flag SHALL then clear.
REQ-023 SHALL set pc <= pc+1 at the end of WB for every other non-halt mode.
REQ-024 SHALL let pc wrap from 2^PC_W-1 to 0 with no flag.
REQ-025 SHALL ignore start outside IDLE and HALT.
REQ-026 SHALL, on start (from IDLE or HALT), set pc <= 0, cyc_cnt <= 0 and eq_flag <= 0.
REQ-027 SHALL increment cyc_cnt every cycle in FETCH, DECODE, EXEC and WB, saturating at 16'hFFFF.
REQ-028 SHALL hold cyc_cnt in HALT and IDLE.
REQ-029 SHALL assert done exactly while in HALT.
REQ-030 SHALL take exactly 4 cycles per instruction, with no pipelining or overlap.
REQ-031 SHALL hold pc stable from FETCH through EXEC.

Reset
REQ-032 SHALL, while rst_n=0, force state IDLE, pc=0, IR=0, eq_flag=0, cyc_cnt=0 and all strobes 0, asynchronously.
REQ-033 SHALL abort an instruction in flight on reset mid-instruction, with no wen or mem_we pulse emitted afterward.
REQ-034 SHALL leave IDLE after reset release only on a start pulse.

Verification
REQ-035 SHALL be verified by: reset, start, IMEM[0]=9'b111_010_000 -> wen=1 only in cycle 4 after start, AccControl=7, imm=8'h10, pc=1 in cycle 5.
REQ-036 SHALL be verified by: IMEM[0]=EQ r1,r2 (rd1=rd2=8'h05), IMEM[1]=mode 4 with rd1=8'h20 -> pc=0x020 after 8 cycles, no wen pulses.
REQ-037 SHALL be verified by: EQ with rd1=5, rd2=6 followed by mode 4 -> pc=2, with the flag cleared.
REQ-038 SHALL be verified by: IMEM[0]=mode 6 -> mem_re in cycle 3, wen in cycle 4; IMEM[1]=mode 5 -> mem_we in cycle 8 only.
REQ-039 SHALL be verified by: IMEM[0]=mode 0 -> done=1 from cycle 5, cyc_cnt=4, held for 10 cycles; a second start -> done=0, pc=0, cyc_cnt restarts.
REQ-040 SHALL be verified by: rst_n low during EXEC of mode 1 -> no wen pulse, and all outputs 0 immediately; start during EXEC is ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- multi-cycle instruction fetch/decode controller.
//
// Walks each instruction through FETCH, DECODE, EXEC and WB (four cycles,
// no overlap) and drives the register-file and data-memory controls
// decoded from the latched instruction register. Mode 0 halts the machine
// until the next start pulse. Mode 3 compares the two register reads into
// an equality flag, and mode 4 branches to rd1 when that flag is set.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse, honoured only in IDLE or HALT
//   pc          instruction memory address
//   instr       instruction memory data for the current pc
//   rd1, rd2    register-file read data
//   wen         register-file write enable (WB of modes 1,2,6,7)
//   AccControl  instruction mode while DECODE/EXEC/WB, else 0
//   ra1, ra2    register-file read addresses while DECODE/EXEC/WB, else 0
//   imm         zero-extended IR[5:0]
//   mem_we      data-memory write strobe (WB of mode 5)
//   mem_re      data-memory read strobe (EXEC of mode 6)
//   done        high while halted
//   cyc_cnt     saturating count of active cycles since start
module fetch_ctrl #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic [8:0]      instr,
  input  logic [7:0]      rd1,
  input  logic [7:0]      rd2,
  output logic            wen,
  output logic [2:0]      AccControl,
  output logic [2:0]      ra1,
  output logic [2:0]      ra2,
  output logic [7:0]      imm,
  output logic            mem_we,
  output logic            mem_re,
  output logic            done,
  output logic [15:0]     cyc_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic            eq_q, eq_d;
  logic [7:0]      tgt_q, tgt_d;
  logic [15:0]     cyc_q, cyc_d;

  logic [2:0]      mode;
  logic            busy;
  logic            decoded;

  assign mode    = ir_q[8:6];
  assign busy    = (state_q == FETCH) || (state_q == DECODE) ||
                   (state_q == EXEC)  || (state_q == WB);
  // The IR only holds the current instruction from DECODE onward; in FETCH
  // it still carries the previous one, so field outputs stay quiet there.
  assign decoded = (state_q == DECODE) || (state_q == EXEC) || (state_q == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      eq_q    <= 1'b0;
      tgt_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      eq_q    <= eq_d;
      tgt_q   <= tgt_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    eq_d    = eq_q;
    tgt_d   = tgt_q;
    cyc_d   = cyc_q;

    if (busy && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end

    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
          cyc_d   = '0;
          eq_d    = 1'b0;
        end
      end
      FETCH: begin
        state_d = DECODE;
        ir_d    = instr;
      end
      DECODE: begin
        state_d = EXEC;
      end
      EXEC: begin
        state_d = WB;
        if (mode == 3'd3) begin
          eq_d = (rd1 == rd2);
        end
        // Branch target is captured here because rd1 is only guaranteed
        // to reflect ra1 while the instruction is being executed.
        if (mode == 3'd4) begin
          tgt_d = rd1;
        end
      end
      WB: begin
        if (mode == 3'd0) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
          pc_d    = pc_q + PC_W'(1);
          if (mode == 3'd4) begin
            if (eq_q) begin
              pc_d = PC_W'(tgt_q);
            end
            eq_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pc         = pc_q;
    cyc_cnt    = cyc_q;
    imm        = {2'b00, ir_q[5:0]};
    done       = (state_q == HALT);
    AccControl = decoded ? mode      : 3'd0;
    ra1        = decoded ? ir_q[5:3] : 3'd0;
    ra2        = decoded ? ir_q[2:0] : 3'd0;
    wen        = (state_q == WB) &&
                 ((mode == 3'd1) || (mode == 3'd2) || (mode == 3'd6) || (mode == 3'd7));
    mem_re     = (state_q == EXEC) && (mode == 3'd6);
    mem_we     = (state_q == WB) && (mode == 3'd5);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: instruction memory and register file are
// modelled as combinational arrays; an instruction-level model pushes one
// expected output record per cycle, and the records are popped and compared
// against the DUT on each falling edge.
module tb_fetch_ctrl;

  localparam int PC_W = 10;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] pc;
  logic [8:0]      instr;
  logic [7:0]      rd1;
  logic [7:0]      rd2;
  logic            wen;
  logic [2:0]      AccControl;
  logic [2:0]      ra1;
  logic [2:0]      ra2;
  logic [7:0]      imm;
  logic            mem_we;
  logic            mem_re;
  logic            done;
  logic [15:0]     cyc_cnt;

  logic [8:0] imem [0:1023];
  logic [7:0] rf   [0:7];

  typedef struct {
    logic [9:0]  pc;
    logic        wen;
    logic        memWe;
    logic        memRe;
    logic        isDone;
    logic [2:0]  acc;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [7:0]  imm;
    logic [15:0] cyc;
  } expT;

  expT        expQ[$];
  int         nChecks = 0;
  int         nFails  = 0;
  logic [8:0] lastIr;

  fetch_ctrl #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pc         (pc),
    .instr      (instr),
    .rd1        (rd1),
    .rd2        (rd2),
    .wen        (wen),
    .AccControl (AccControl),
    .ra1        (ra1),
    .ra2        (ra2),
    .imm        (imm),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .done       (done),
    .cyc_cnt    (cyc_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memories so instr and the read data follow their addresses.
  assign instr = imem[pc];
  assign rd1   = rf[ra1];
  assign rd2   = rf[ra2];

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Fill instruction memory with mode-1 instructions and clear the registers.
  task automatic loadDefault();
    for (int i = 0; i < 1024; i++) imem[i] = 9'b001_000_000;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  endtask

  // Hold reset for two cycles and release it on a falling edge.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    lastIr = 9'd0;
    rst_n = 1'b1;
  endtask

  // Instruction-level model: pushes four records per instruction, starting
  // at pc 0, and haltCycles records of the halted state if mode 0 is hit.
  task automatic pushExpected(input int nInstr, input int haltCycles);
    logic [9:0]  mpc;
    logic        meq;
    logic [15:0] mcyc;
    logic [8:0]  w;
    logic [2:0]  m;
    expT         e;
    mpc  = 10'd0;
    meq  = 1'b0;
    mcyc = 16'd0;
    for (int i = 0; i < nInstr; i++) begin
      w = imem[mpc];
      m = w[8:6];
      for (int ph = 0; ph < 4; ph++) begin
        if (ph >= 1) lastIr = w;
        e.pc     = mpc;
        e.isDone = 1'b0;
        e.cyc    = mcyc;
        e.imm    = {2'b00, lastIr[5:0]};
        e.acc    = (ph == 0) ? 3'd0 : m;
        e.r1     = (ph == 0) ? 3'd0 : w[5:3];
        e.r2     = (ph == 0) ? 3'd0 : w[2:0];
        e.wen    = (ph == 3) && ((m == 3'd1) || (m == 3'd2) || (m == 3'd6) || (m == 3'd7));
        e.memRe  = (ph == 2) && (m == 3'd6);
        e.memWe  = (ph == 3) && (m == 3'd5);
        expQ.push_back(e);
        mcyc = mcyc + 16'd1;
      end
      if (m == 3'd0) begin
        for (int h = 0; h < haltCycles; h++) begin
          e.pc     = mpc;
          e.isDone = 1'b1;
          e.cyc    = mcyc;
          e.imm    = {2'b00, lastIr[5:0]};
          e.acc    = 3'd0;
          e.r1     = 3'd0;
          e.r2     = 3'd0;
          e.wen    = 1'b0;
          e.memRe  = 1'b0;
          e.memWe  = 1'b0;
          expQ.push_back(e);
        end
        break;
      end else if (m == 3'd3) begin
        meq = (rf[w[5:3]] == rf[w[2:0]]);
        mpc = mpc + 10'd1;
      end else if (m == 3'd4) begin
        mpc = meq ? {2'b00, rf[w[5:3]]} : mpc + 10'd1;
        meq = 1'b0;
      end else begin
        mpc = mpc + 10'd1;
      end
    end
  endtask

  // Pulse start, then compare one expected record per cycle until the
  // queue is drained. Cycle 1 is the first FETCH after the start edge.
  task automatic applyStimulus(input string name, input int nInstr, input int haltCycles);
    expT e;
    int  k;
    pushExpected(nInstr, haltCycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 1;
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checkOutput($sformatf("%s pc c%0d", name, k),   16'(pc),         16'(e.pc));
      checkOutput($sformatf("%s wen c%0d", name, k),  16'(wen),        16'(e.wen));
      checkOutput($sformatf("%s mwe c%0d", name, k),  16'(mem_we),     16'(e.memWe));
      checkOutput($sformatf("%s mre c%0d", name, k),  16'(mem_re),     16'(e.memRe));
      checkOutput($sformatf("%s done c%0d", name, k), 16'(done),       16'(e.isDone));
      checkOutput($sformatf("%s acc c%0d", name, k),  16'(AccControl), 16'(e.acc));
      checkOutput($sformatf("%s ra1 c%0d", name, k),  16'(ra1),        16'(e.r1));
      checkOutput($sformatf("%s ra2 c%0d", name, k),  16'(ra2),        16'(e.r2));
      checkOutput($sformatf("%s imm c%0d", name, k),  16'(imm),        16'(e.imm));
      checkOutput($sformatf("%s cyc c%0d", name, k),  cyc_cnt,         e.cyc);
      k++;
    end
  endtask

  // All outputs of an idle or reset controller read as zero.
  task automatic checkAllZero(input string name);
    checkOutput({name, " pc"},   16'(pc),         16'h0);
    checkOutput({name, " wen"},  16'(wen),        16'h0);
    checkOutput({name, " mwe"},  16'(mem_we),     16'h0);
    checkOutput({name, " mre"},  16'(mem_re),     16'h0);
    checkOutput({name, " done"}, 16'(done),       16'h0);
    checkOutput({name, " acc"},  16'(AccControl), 16'h0);
    checkOutput({name, " ra1"},  16'(ra1),        16'h0);
    checkOutput({name, " ra2"},  16'(ra2),        16'h0);
    checkOutput({name, " imm"},  16'(imm),        16'h0);
    checkOutput({name, " cyc"},  cyc_cnt,         16'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    lastIr = 9'd0;
    loadDefault();
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 7 write-back with immediate 0x10, followed by a default instruction.
    imem[0] = 9'b111_010_000;
    applyStimulus("m7", 2, 0);
    doReset();

    // Equal compare then branch to 0x20; the branch there must fall through
    // because the flag was consumed, reaching a halt at 0x21.
    loadDefault();
    rf[1] = 8'h05;
    rf[2] = 8'h05;
    rf[3] = 8'h20;
    imem[0]    = 9'b011_001_010;
    imem[1]    = 9'b100_011_000;
    imem[8'h20] = 9'b100_011_000;
    imem[8'h21] = 9'b000_000_000;
    applyStimulus("beq", 4, 3);

    // Unequal compare: branch not taken, lands on a halt at pc 2.
    rf[2]   = 8'h06;
    imem[2] = 9'b000_000_000;
    applyStimulus("bne", 3, 2);

    // Load (mode 6) then store (mode 5), then halt.
    loadDefault();
    imem[0] = 9'b110_001_010;
    imem[1] = 9'b101_011_100;
    imem[2] = 9'b000_000_000;
    applyStimulus("ldst", 3, 2);

    // Halt held for ten cycles, then a restart from HALT.
    doReset();
    loadDefault();
    imem[0] = 9'b000_000_000;
    applyStimulus("halt", 1, 10);
    applyStimulus("rehalt", 1, 2);

    // Start during EXEC is ignored; reset during the next EXEC aborts.
    doReset();
    loadDefault();
    imem[0] = 9'b001_010_011;
    imem[1] = 9'b001_010_011;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ign exec acc", 16'(AccControl), 16'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("ign wb wen", 16'(wen), 16'd1);
    checkOutput("ign wb pc",  16'(pc),  16'd0);
    @(negedge clk);
    checkOutput("ign next pc",  16'(pc),      16'd1);
    checkOutput("ign next cyc", cyc_cnt,      16'd4);
    repeat (2) @(negedge clk);
    checkOutput("abort exec acc", 16'(AccControl), 16'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post wen %0d", i),  16'(wen),    16'd0);
      checkOutput($sformatf("post mwe %0d", i),  16'(mem_we), 16'd0);
      checkOutput($sformatf("post pc %0d", i),   16'(pc),     16'd0);
      checkOutput($sformatf("post cyc %0d", i),  cyc_cnt,     16'd0);
    end
    lastIr = 9'd0;

    // Run past the top of instruction memory so pc wraps back to 0.
    doReset();
    loadDefault();
    applyStimulus("wrap", 1025, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
